button_debounce: RTL and testbench

BUTTON_DEBOUNCE -- requirements
Module: button_debounce

---
 rtl/button_pkg.sv | 15 +
 rtl/sync_2ff.sv | 23 ++
 rtl/button_debounce.sv | 145 ++++++++++++++
 tb/tb_button_debounce.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// Shared types and default parameter values for the button debouncer.
package button_pkg;

  typedef enum logic [1:0] {
    RELEASED  = 2'd0,
    ARMING    = 2'd1,
    PRESSED   = 2'd2,
    DISARMING = 2'd3
  } state_t;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 4;
  localparam int DEFAULT_LONG_CYCLES     = 64;
  localparam int DEFAULT_ACTIVE_LOW      = 0;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous single-bit input.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_debounce.sv
// Debounces a raw switch input into a clean level plus press, release and
// long-press pulses.
//
// state     | meaning
// RELEASED  | button idle, level = 0
// ARMING    | counting stable active samples toward a press
// PRESSED   | button held, level = 1, long counter running
// DISARMING | counting stable inactive samples toward a release, level = 1
module button_debounce
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int LONG_CYCLES     = DEFAULT_LONG_CYCLES,
  parameter int ACTIVE_LOW      = DEFAULT_ACTIVE_LOW
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic level,
  output logic press,
  // 'release' is a reserved word, hence the suffix
  output logic release_pulse,
  output logic long_press
);

  localparam int   DW  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int   LW  = $clog2(LONG_CYCLES + 1);
  localparam logic INV = (ACTIVE_LOW != 0);

  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [LW-1:0] LONG_LAST = LW'(LONG_CYCLES - 1);
  localparam logic [LW-1:0] LONG_SAT  = LW'(LONG_CYCLES);

  logic sync_raw;
  logic sync;

  // Synchronizer resets to the inactive raw level so a button held through
  // reset is seen as a fresh edge and fully debounced.
  sync_2ff #(
    .RESET_VAL(INV)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (btn_in),
    .q    (sync_raw)
  );

  assign sync = sync_raw ^ INV;

  state_t          state, state_n;
  logic [DW-1:0]   deb_cnt, deb_n;
  logic [LW-1:0]   long_cnt, long_n;
  logic            level_n, press_n, release_n, long_press_n;
  logic            long_adv;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= RELEASED;
      deb_cnt       <= '0;
      long_cnt      <= '0;
      level         <= 1'b0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
      long_press    <= 1'b0;
    end else begin
      state         <= state_n;
      deb_cnt       <= deb_n;
      long_cnt      <= long_n;
      level         <= level_n;
      press         <= press_n;
      release_pulse <= release_n;
      long_press    <= long_press_n;
    end
  end

  always_comb begin
    state_n      = state;
    deb_n        = deb_cnt;
    long_n       = long_cnt;
    press_n      = 1'b0;
    release_n    = 1'b0;
    long_press_n = 1'b0;
    long_adv     = 1'b0;

    case (state)
      RELEASED: begin
        if (sync) begin
          state_n = ARMING;
          deb_n   = DW'(1);
        end
      end
      ARMING: begin
        if (!sync) begin
          state_n = RELEASED;
          deb_n   = '0;
        end else if (deb_cnt == DEB_LAST) begin
          state_n = PRESSED;
          deb_n   = '0;
          long_n  = '0;
          press_n = 1'b1;
        end else begin
          deb_n = deb_cnt + DW'(1);
        end
      end
      PRESSED: begin
        if (!sync) begin
          state_n = DISARMING;
          deb_n   = DW'(1);
        end else begin
          long_adv = 1'b1;
        end
      end
      DISARMING: begin
        if (sync) begin
          state_n  = PRESSED;
          deb_n    = '0;
          long_adv = 1'b1;
        end else if (deb_cnt == DEB_LAST) begin
          state_n   = RELEASED;
          deb_n     = '0;
          release_n = 1'b1;
        end else begin
          deb_n = deb_cnt + DW'(1);
        end
      end
      default: begin
        state_n = RELEASED;
        deb_n   = '0;
      end
    endcase

    // Long counter saturates at LONG_CYCLES so the pulse fires exactly once.
    if (long_adv) begin
      if (long_cnt == LONG_LAST) begin
        long_n       = LONG_SAT;
        long_press_n = 1'b1;
      end else if (long_cnt != LONG_SAT) begin
        long_n = long_cnt + LW'(1);
      end
    end

    level_n = (state_n == PRESSED) || (state_n == DISARMING);
  end

endmodule

// File: tb/tb_button_debounce.sv
// Scoreboard bench: stimulus queues expected pulses/levels by edge number,
// a negedge monitor pops and compares for an active-high and an active-low DUT.
module tb_button_debounce;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn = 1'b0;
  logic       btn_n;
  logic [1:0] level, press, rel, lp;

  assign btn_n = ~btn;

  button_debounce #(.DEBOUNCE_CYCLES(4), .LONG_CYCLES(10), .ACTIVE_LOW(0)) dut_h (
    .clk(clk), .reset(reset), .btn_in(btn),
    .level(level[0]), .press(press[0]), .release_pulse(rel[0]), .long_press(lp[0])
  );

  button_debounce #(.DEBOUNCE_CYCLES(4), .LONG_CYCLES(10), .ACTIVE_LOW(1)) dut_l (
    .clk(clk), .reset(reset), .btn_in(btn_n),
    .level(level[1]), .press(press[1]), .release_pulse(rel[1]), .long_press(lp[1])
  );

  always #5 clk = ~clk;

  // val: pulse kind 0=press 1=release 2=long; level want 0/1, 2=all outputs quiet
  typedef struct {
    int edge_no;
    int val;
  } ev_t;

  ev_t pq[2][$];
  ev_t lq[2][$];
  int  checks = 0;
  int  errors = 0;
  int  e = -1;

  always @(posedge clk) e <= e + 1;

  task automatic push_pulse(input int kind, input int at);
    for (int d = 0; d < 2; d++) pq[d].push_back('{edge_no: at, val: kind});
  endtask

  task automatic push_lvl(input int want, input int at);
    for (int d = 0; d < 2; d++) lq[d].push_back('{edge_no: at, val: want});
  endtask

  task automatic run_to(input int t);
    while (e < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_release();
    int k;
    btn = 1'b0;
    k = e + 1;
    push_lvl(1, k + 4);
    push_lvl(0, k + 5);
    push_pulse(1, k + 5);
    run_to(k + 8);
  endtask

  always @(negedge clk) begin
    ev_t        x;
    logic [2:0] p;
    for (int d = 0; d < 2; d++) begin
      p = {lp[d], rel[d], press[d]};
      while (lq[d].size() > 0 && lq[d][0].edge_no <= e) begin
        x = lq[d].pop_front();
        checks++;
        if (x.edge_no != e) begin
          errors++;
          $display("FAIL level_missed dut%0d: checked at edge %0d, required edge %0d", d, e, x.edge_no);
        end else if (x.val == 2) begin
          if ({level[d], p} != 4'b0000) begin
            errors++;
            $display("FAIL quiet dut%0d edge %0d: got level/long/rel/press=%b, required 0000",
                     d, e, {level[d], p});
          end
        end else if (level[d] != x.val[0]) begin
          errors++;
          $display("FAIL level dut%0d edge %0d: got %0b, required %0d", d, e, level[d], x.val);
        end
      end
      if (p != 3'b000) begin
        checks++;
        if (pq[d].size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse dut%0d edge %0d: got long/rel/press=%b, required none", d, e, p);
        end else begin
          x = pq[d].pop_front();
          if (p != (3'b001 << x.val) || x.edge_no != e) begin
            errors++;
            $display("FAIL pulse dut%0d: got long/rel/press=%b at edge %0d, required %b at edge %0d",
                     d, p, e, 3'b001 << x.val, x.edge_no);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int b, j, p0, p1;

    // reset with button idle
    reset = 1'b1;
    btn   = 1'b0;
    run_to(1);
    push_lvl(2, e);
    reset = 1'b0;
    run_to(e + 3);

    // clean press, long press, no repeat, then release
    btn = 1'b1;
    b = e + 1;
    push_lvl(0, b + 4);
    push_lvl(1, b + 5);
    push_pulse(0, b + 5);
    push_lvl(1, b + 15);
    push_pulse(2, b + 15);
    run_to(b + 20);
    do_release();

    // three-sample glitch must be rejected
    btn = 1'b1;
    b = e + 1;
    push_lvl(0, b + 3);
    push_lvl(0, b + 5);
    push_lvl(0, b + 8);
    run_to(b + 2);
    btn = 1'b0;
    run_to(b + 10);

    // release glitch of two samples delays long press by two cycles
    btn = 1'b1;
    b = e + 1;
    push_lvl(1, b + 5);
    push_pulse(0, b + 5);
    run_to(b + 6);
    btn = 1'b0;
    j = e + 1;
    push_lvl(1, j + 2);
    push_lvl(1, j + 4);
    push_lvl(1, j + 6);
    push_pulse(2, b + 17);
    run_to(j + 1);
    btn = 1'b1;
    run_to(b + 20);
    do_release();

    // reset in ARMING, then in PRESSED, with button held throughout
    btn = 1'b1;
    b = e + 1;
    run_to(b + 2);
    reset = 1'b1;
    run_to(b + 3);
    push_lvl(2, e);
    reset = 1'b0;
    p0 = e + 1;
    push_lvl(2, p0);
    push_lvl(0, p0 + 4);
    push_lvl(1, p0 + 5);
    push_pulse(0, p0 + 5);
    run_to(p0 + 7);
    reset = 1'b1;
    run_to(p0 + 8);
    push_lvl(2, e);
    reset = 1'b0;
    p1 = e + 1;
    push_lvl(2, p1);
    push_lvl(0, p1 + 4);
    push_lvl(1, p1 + 5);
    push_pulse(0, p1 + 5);
    push_pulse(2, p1 + 15);
    run_to(p1 + 18);
    do_release();

    run_to(e + 5);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (pq[d].size() != 0) begin
        errors++;
        $display("FAIL pending_pulses dut%0d: got %0d outstanding, required 0", d, pq[d].size());
      end
      checks++;
      if (lq[d].size() != 0) begin
        errors++;
        $display("FAIL pending_levels dut%0d: got %0d outstanding, required 0", d, lq[d].size());
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
